fifo_read_ctrl: RTL and testbench
=================================

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 8, RAM address width; FIFO depth is 2^ADDR_SIZE; pointer width is ADDR_SIZE+1.
REQ-002 The block SHALL have parameter AE_THRESH, default 4, almost-empty level threshold (0..2^ADDR_SIZE).
REQ-003 The block SHALL have port r_clk_i  in  1  read-domain clock; one clock only; all logic on rising edge.
REQ-004 The block SHALL have port r_rst_i  in  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port r_en_i  in  1  read request from consumer.
REQ-006 The block SHALL have port underflow_clr_i  in  1  clears sticky underflow flag.
REQ-007 The block SHALL have port rw_ptr_i  in  ADDR_SIZE+1  Gray-coded write pointer, already synchronized into r_clk_i domain.
REQ-008 The block SHALL have port r_ptr_o  out  ADDR_SIZE+1  registered Gray-coded read pointer, sent to the write-domain synchronizer.
REQ-009 The block SHALL have port r_addr_o  out  ADDR_SIZE  binary RAM read address.
REQ-010 The block SHALL have port r_ren_o  out  1  RAM read enable (accepted read).
REQ-011 The block SHALL have port r_valid_o  out  1  read data valid at RAM output.
REQ-012 The block SHALL have port empty_o  out  1  FIFO empty, registered.
REQ-013 The block SHALL have port almost_empty_o  out  1  level <= AE_THRESH, registered.
REQ-014 The block SHALL have port r_level_o  out  ADDR_SIZE+1  registered occupancy, 0..2^ADDR_SIZE.
REQ-015 The block SHALL have port underflow_o  out  1  sticky underflow flag.

Function
REQ-016 The block SHALL define accepted read as r_en_i AND NOT empty_o; r_ren_o SHALL equal accepted read combinationally.
REQ-017 The block SHALL hold internal binary pointer r_bin (ADDR_SIZE+1 bits); next_bin = r_bin + accepted read, modulo 2^(ADDR_SIZE+1); all-ones wraps to 0.
REQ-018 The block SHALL register r_ptr_o <= next_bin ^ (next_bin >> 1) in the same edge as r_bin <= next_bin; r_ptr_o changes at most one bit per cycle.
REQ-019 The block SHALL drive r_addr_o = r_bin[ADDR_SIZE-1:0] (registered pointer, no combinational path from r_en_i).
REQ-020 The block SHALL assert r_valid_o for exactly one cycle, the cycle after each accepted read (synchronous RAM latency 1); back-to-back reads give continuous r_valid_o.
REQ-021 The block SHALL register empty_o <= (next_gray == rw_ptr_i), where next_gray is the value loaded into r_ptr_o.
REQ-022 The block SHALL convert rw_ptr_i to binary w_bin (bit i = XOR of Gray bits ADDR_SIZE..i) and register r_level_o <= (w_bin - next_bin) modulo 2^(ADDR_SIZE+1).
REQ-023 The block SHALL register almost_empty_o <= (w_bin - next_bin) <= AE_THRESH.
REQ-024 The block SHALL set underflow_o on any cycle with r_en_i=1 and empty_o=1; it SHALL hold until underflow_clr_i=1; if set and clear coincide, set wins.
REQ-025 The block SHALL ignore reads while empty: r_bin, r_ptr_o, r_addr_o unchanged, r_ren_o=0, r_valid_o=0 next cycle.
REQ-026 The block SHALL evaluate empty_o on the same edge as the last read using the rw_ptr_i value sampled at that edge; a write arriving that cycle SHALL deassert empty_o no later than the following edge.
REQ-027 The block SHALL NOT reduce empty_o, almost_empty_o or r_level_o on any rw_ptr_i change other than via REQ-021..023 (pessimistic: stale rw_ptr_i only under-reports level).

Reset
REQ-028 The block SHALL, while r_rst_i=1 (asynchronous), force r_bin=0, r_ptr_o=0, r_addr_o=0, r_valid_o=0, empty_o=1, almost_empty_o=1, r_level_o=0, underflow_o=0.
REQ-029 The block SHALL keep r_ren_o=0 throughout reset (empty_o=1 gates it).
REQ-030 The block SHALL, on reset asserted mid-operation, discard in-flight state immediately; the first edge after release evaluates REQ-021..023 against current rw_ptr_i.

Verification (ADDR_SIZE=3, AE_THRESH=2 unless stated)
REQ-031 Reset, rw_ptr_i=0, r_en_i=1 for 5 cycles -> empty_o=1, r_ren_o=0, r_ptr_o=0, underflow_o=1 after first edge; pulse underflow_clr_i with r_en_i=0 -> underflow_o=0.
REQ-032 rw_ptr_i=Gray(5)=0111 -> next edge empty_o=0, r_level_o=5, almost_empty_o=0; 5 back-to-back reads -> r_addr_o 0..4, r_valid_o high 5 cycles lagged by 1, r_level_o 4,3,2,1,0, almost_empty_o at level 2, empty_o=1 after 5th read, 6th request ignored.
REQ-033 Wrap: 16 writes/reads total with rw_ptr_i stepping in Gray -> r_ptr_o sequence 0000..1000 then back to 0000, exactly one bit changes per step, r_addr_o wraps 7->0.
REQ-034 Full: rw_ptr_i=Gray(8)=1100, r_bin=0 -> r_level_o=8, empty_o=0, almost_empty_o=0.
REQ-035 Reset asserted mid-burst (level 3) -> outputs reach REQ-028 values without a clock edge; after release with rw_ptr_i=0011 (Gray 2) -> r_level_o=2, empty_o=0, almost_empty_o=1.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
// Read-side controller of an asynchronous FIFO. It owns the read pointer,
// which is kept both in binary (RAM address) and in Gray code (crossing to the
// write domain). It derives empty, almost-empty and occupancy from the write
// pointer, which arrives already synchronized into this domain. It also keeps
// a sticky flag for reads attempted while the FIFO is empty.
//
// All status flags are computed from the pointer value being loaded on the
// current edge. This keeps them consistent with r_ptr_o in the same cycle.
// A stale write pointer can only make the FIFO look emptier than it is,
// never fuller, so the flags are pessimistic in the safe direction.
// -----------------------------------------------------------------------------
module fifo_read_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int AE_THRESH = 4
) (
    input  logic                 r_clk_i,
    input  logic                 r_rst_i,
    input  logic                 r_en_i,
    input  logic                 underflow_clr_i,
    input  logic [ADDR_SIZE:0]   rw_ptr_i,
    output logic [ADDR_SIZE:0]   r_ptr_o,
    output logic [ADDR_SIZE-1:0] r_addr_o,
    output logic                 r_ren_o,
    output logic                 r_valid_o,
    output logic                 empty_o,
    output logic                 almost_empty_o,
    output logic [ADDR_SIZE:0]   r_level_o,
    output logic                 underflow_o
);

    // Pointer width: one extra bit distinguishes full from empty.
    localparam int PW = ADDR_SIZE + 1;

    // Almost-empty threshold expressed at pointer width for the compare.
    localparam logic [PW-1:0] AE_THRESH_C = PW'(AE_THRESH);

    // -------------------------------------------------------------------------
    // Pointer encoding helpers
    // -------------------------------------------------------------------------

    // Binary to reflected Gray code.
    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code to binary: each bit is the XOR of all higher Gray bits.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [PW-1:0]        r_bin_r;
    logic [PW-1:0]        r_ptr_r;
    logic                 r_valid_r;
    logic                 empty_r;
    logic                 almost_empty_r;
    logic [PW-1:0]        r_level_r;
    logic                 underflow_r;

    // -------------------------------------------------------------------------
    // Next-state signals
    // -------------------------------------------------------------------------
    logic                 rd_acc_s;
    logic                 rd_under_s;
    logic [PW-1:0]        next_bin_s;
    logic [PW-1:0]        next_gray_s;
    logic [PW-1:0]        w_bin_s;
    logic [PW-1:0]        level_next_s;
    logic                 empty_next_s;
    logic                 almost_empty_next_s;

    // Read acceptance, next pointer values and the status flags they imply.
    always_comb begin
        rd_acc_s            = 1'b0;
        rd_under_s          = 1'b0;
        next_bin_s          = r_bin_r;
        next_gray_s         = r_ptr_r;
        w_bin_s             = gray2bin(rw_ptr_i);
        level_next_s        = '0;
        empty_next_s        = 1'b1;
        almost_empty_next_s = 1'b1;

        // A read is taken only when the registered empty flag allows it.
        // While empty, the request is counted as an underflow attempt.
        if (r_en_i == 1'b1) begin
            rd_acc_s   = ~empty_r;
            rd_under_s = empty_r;
        end else begin
            rd_acc_s   = 1'b0;
            rd_under_s = 1'b0;
        end

        // The pointer wraps naturally at 2^PW through modulo arithmetic.
        next_bin_s   = r_bin_r + {{(PW-1){1'b0}}, rd_acc_s};
        next_gray_s  = bin2gray(next_bin_s);

        // Occupancy is seen from the pointer being loaded on this edge.
        level_next_s = w_bin_s - next_bin_s;

        if (next_gray_s == rw_ptr_i) begin
            empty_next_s = 1'b1;
        end else begin
            empty_next_s = 1'b0;
        end

        if (level_next_s <= AE_THRESH_C) begin
            almost_empty_next_s = 1'b1;
        end else begin
            almost_empty_next_s = 1'b0;
        end
    end

    // Read pointer, data-valid pipeline and status flags. Reset forces the
    // safe "empty" view.
    always_ff @(posedge r_clk_i or posedge r_rst_i) begin
        if (r_rst_i) begin
            r_bin_r        <= '0;
            r_ptr_r        <= '0;
            r_valid_r      <= 1'b0;
            empty_r        <= 1'b1;
            almost_empty_r <= 1'b1;
            r_level_r      <= '0;
        end else begin
            r_bin_r        <= next_bin_s;
            r_ptr_r        <= next_gray_s;
            r_valid_r      <= rd_acc_s;
            empty_r        <= empty_next_s;
            almost_empty_r <= almost_empty_next_s;
            r_level_r      <= level_next_s;
        end
    end

    // Sticky underflow flag. A new underflow takes priority over a clear
    // in the same cycle, so no event is lost.
    always_ff @(posedge r_clk_i or posedge r_rst_i) begin
        if (r_rst_i) begin
            underflow_r <= 1'b0;
        end else if (rd_under_s) begin
            underflow_r <= 1'b1;
        end else if (underflow_clr_i) begin
            underflow_r <= 1'b0;
        end else begin
            underflow_r <= underflow_r;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------

    // The RAM enable must reach the RAM in the same cycle as the request,
    // so it is the only combinational output. It is gated by the registered
    // empty flag, which also holds it low throughout reset.
    assign r_ren_o        = rd_acc_s;
    assign r_addr_o       = r_bin_r[ADDR_SIZE-1:0];
    assign r_ptr_o        = r_ptr_r;
    assign r_valid_o      = r_valid_r;
    assign empty_o        = empty_r;
    assign almost_empty_o = almost_empty_r;
    assign r_level_o      = r_level_r;
    assign underflow_o    = underflow_r;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_ctrl
// Self-checking bench for fifo_read_ctrl with ADDR_SIZE=3 and AE_THRESH=2.
// A vector table covers reset and the underflow and drain sequences.
// Hand-written loops cover pointer wrap, a full FIFO and reset in mid-burst.
// r_valid_o is checked through a queue. The expected value is pushed when a
// request is driven and popped after the following edge.
// -----------------------------------------------------------------------------
module tb_fifo_read_ctrl;

    localparam int AS = 3;
    localparam int PW = AS + 1;

    logic          clk;
    logic          rst;
    logic          r_en;
    logic          clr;
    logic [PW-1:0] w_ptr;
    logic [PW-1:0] r_ptr_o;
    logic [AS-1:0] r_addr_o;
    logic          r_ren_o;
    logic          r_valid_o;
    logic          empty_o;
    logic          almost_empty_o;
    logic [PW-1:0] r_level_o;
    logic          underflow_o;

    int checks   = 0;
    int failures = 0;

    logic exp_valid_q[$];

    typedef struct {
        logic          en;
        logic          clr;
        logic [PW-1:0] w;
        logic          ren;
        logic [AS-1:0] addr;
        logic [PW-1:0] ptr;
        logic          empty;
        logic          ae;
        logic [PW-1:0] level;
        logic          uf;
    } vec_t;

    vec_t tbl[$];

    fifo_read_ctrl #(
        .ADDR_SIZE (AS),
        .AE_THRESH (2)
    ) dut (
        .r_clk_i         (clk),
        .r_rst_i         (rst),
        .r_en_i          (r_en),
        .underflow_clr_i (clr),
        .rw_ptr_i        (w_ptr),
        .r_ptr_o         (r_ptr_o),
        .r_addr_o        (r_addr_o),
        .r_ren_o         (r_ren_o),
        .r_valid_o       (r_valid_o),
        .empty_o         (empty_o),
        .almost_empty_o  (almost_empty_o),
        .r_level_o       (r_level_o),
        .underflow_o     (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic vec_t mk(input logic en, input logic c, input logic [PW-1:0] w,
                                input logic ren, input logic [AS-1:0] addr,
                                input logic [PW-1:0] ptr, input logic empty,
                                input logic ae, input logic [PW-1:0] level,
                                input logic uf);
        vec_t v;
        v.en = en; v.clr = c; v.w = w; v.ren = ren; v.addr = addr; v.ptr = ptr;
        v.empty = empty; v.ae = ae; v.level = level; v.uf = uf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and check both sides of the edge.
    task automatic apply(input vec_t v, input string tag);
        logic ev;
        r_en  = v.en;
        clr   = v.clr;
        w_ptr = v.w;
        exp_valid_q.push_back(v.ren);
        #1;
        chk({tag, ".ren"}, {31'd0, r_ren_o}, {31'd0, v.ren});
        @(posedge clk);
        #1;
        chk({tag, ".addr"},  {29'd0, r_addr_o},       {29'd0, v.addr});
        chk({tag, ".ptr"},   {28'd0, r_ptr_o},        {28'd0, v.ptr});
        chk({tag, ".empty"}, {31'd0, empty_o},        {31'd0, v.empty});
        chk({tag, ".ae"},    {31'd0, almost_empty_o}, {31'd0, v.ae});
        chk({tag, ".level"}, {28'd0, r_level_o},      {28'd0, v.level});
        chk({tag, ".uf"},    {31'd0, underflow_o},    {31'd0, v.uf});
        if (exp_valid_q.size() > 0) begin
            ev = exp_valid_q.pop_front();
            chk({tag, ".valid"}, {31'd0, r_valid_o}, {31'd0, ev});
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".addr"},  {29'd0, r_addr_o},       32'd0);
        chk({tag, ".ptr"},   {28'd0, r_ptr_o},        32'd0);
        chk({tag, ".valid"}, {31'd0, r_valid_o},      32'd0);
        chk({tag, ".empty"}, {31'd0, empty_o},        32'd1);
        chk({tag, ".ae"},    {31'd0, almost_empty_o}, 32'd1);
        chk({tag, ".level"}, {28'd0, r_level_o},      32'd0);
        chk({tag, ".uf"},    {31'd0, underflow_o},    32'd0);
        chk({tag, ".ren"},   {31'd0, r_ren_o},        32'd0);
    endtask

    initial begin
        logic [PW-1:0] b;
        logic [PW-1:0] prev_ptr;

        // Underflow while empty; set beats clear; clear alone releases.
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0));
        // Five entries written (Gray 5 = 0111), then drained back to back.
        tbl.push_back(mk(1'b0, 1'b0, 4'b0111, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd5, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 4'b0111, 1'b1, 3'd1, 4'b0001, 1'b0, 1'b0, 4'd4, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 4'b0111, 1'b1, 3'd2, 4'b0011, 1'b0, 1'b0, 4'd3, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 4'b0111, 1'b1, 3'd3, 4'b0010, 1'b0, 1'b1, 4'd2, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 4'b0111, 1'b1, 3'd4, 4'b0110, 1'b0, 1'b1, 4'd1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 4'b0111, 1'b1, 3'd5, 4'b0111, 1'b1, 1'b1, 4'd0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 4'b0111, 1'b0, 3'd5, 4'b0111, 1'b1, 1'b1, 4'd0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 4'b0111, 1'b0, 3'd5, 4'b0111, 1'b1, 1'b1, 4'd0, 1'b0));

        // Reset with reads requested: the enable must stay low.
        rst = 1'b1; r_en = 1'b1; clr = 1'b0; w_ptr = 4'b0000;
        #1;
        chk_reset("rst0");
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst1");
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Wrap: one write and one read per step across the full Gray cycle.
        b = 4'd5;
        prev_ptr = r_ptr_o;
        for (int k = 0; k < 16; k++) begin
            apply(mk(1'b0, 1'b0, gray(b + 4'd1), 1'b0, b[AS-1:0], gray(b),
                     1'b0, 1'b1, 4'd1, 1'b0), $sformatf("wrw%0d", k));
            b = b + 4'd1;
            apply(mk(1'b1, 1'b0, gray(b), 1'b1, b[AS-1:0], gray(b),
                     1'b1, 1'b1, 4'd0, 1'b0), $sformatf("wrr%0d", k));
            chk($sformatf("wrap%0d.onebit", k), $countones(r_ptr_o ^ prev_ptr), 32'd1);
            prev_ptr = r_ptr_o;
        end

        // Full FIFO from reset: Gray 8 = 1100 against read pointer 0.
        rst = 1'b1; r_en = 1'b0; w_ptr = 4'b1100;
        #2;
        rst = 1'b0;
        exp_valid_q.delete();
        apply(mk(1'b0, 1'b0, 4'b1100, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd8, 1'b0), "full");
        b = 4'd0;
        for (int k = 0; k < 5; k++) begin
            b = b + 4'd1;
            apply(mk(1'b1, 1'b0, 4'b1100, 1'b1, b[AS-1:0], gray(b), 1'b0, 1'b0,
                     4'd8 - b, 1'b0), $sformatf("burst%0d", k));
        end

        // Reset mid-burst (level 3): outputs clear without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        exp_valid_q.delete();
        r_en = 1'b0; w_ptr = 4'b0011;
        @(posedge clk);
        #1;
        chk_reset("midrst_hold");
        rst = 1'b0;
        apply(mk(1'b0, 1'b0, 4'b0011, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b1, 4'd2, 1'b0), "postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
